// File: rtl/audio_fifo_serializer_if.sv
// Read-side port bundle for the paired left/right show-ahead audio FIFOs.
// master = consumer that issues pops, slave = FIFO pair.
interface audio_fifo_serializer_if #(
    parameter int AUDIO_DATA_WIDTH = 32
);
    logic                        left_fifo_is_empty;
    logic [AUDIO_DATA_WIDTH-1:0] left_read_data;
    logic                        left_read_en;
    logic                        right_fifo_is_empty;
    logic [AUDIO_DATA_WIDTH-1:0] right_read_data;
    logic                        right_read_en;

    modport master (
        input  left_fifo_is_empty, left_read_data, right_fifo_is_empty, right_read_data,
        output left_read_en, right_read_en
    );

    modport slave (
        output left_fifo_is_empty, left_read_data, right_fifo_is_empty, right_read_data,
        input  left_read_en, right_read_en
    );
endinterface

// File: rtl/audio_fifo_serializer.sv
// Pops one stereo pair per LRCLK frame and shifts it out MSB-first as I2S DAC data.
// Define AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN to add a saturating underflow_count port.
module audio_fifo_serializer #(
    parameter int AUDIO_DATA_WIDTH  = 32,
    parameter int BIT_COUNTER_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     bclk_falling_edge,
    input  logic                     lrclk_rising_edge,
    input  logic                     lrclk_falling_edge,
    audio_fifo_serializer_if.master  fifo,
    output logic                     serial_audio_out_data,
    output logic                     underflow
`ifdef AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN
    ,
    output logic [7:0]               underflow_count
`endif
);
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    localparam logic [BIT_COUNTER_WIDTH-1:0] CNT_MAX = BIT_COUNTER_WIDTH'(AUDIO_DATA_WIDTH);

    state_t                        state;
    logic [AUDIO_DATA_WIDTH-1:0]   shift_reg;
    logic [AUDIO_DATA_WIDTH-1:0]   right_hold;
    logic [BIT_COUNTER_WIDTH-1:0]  bit_cnt;
    logic                          frame_start;
    logic                          right_start;
    logic                          pair_ready;
    logic                          pop;

    assign frame_start = enable & lrclk_falling_edge;
    assign right_start = enable & lrclk_rising_edge & (state == LEFT);
    assign pair_ready  = ~fifo.left_fifo_is_empty & ~fifo.right_fifo_is_empty;

    // Both FIFOs pop together or not at all; reset gates the pop without waiting for clk.
    assign pop               = reset & frame_start & pair_ready;
    assign fifo.left_read_en  = pop;
    assign fifo.right_read_en = pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            shift_reg             <= '0;
            right_hold            <= '0;
            bit_cnt               <= '0;
            serial_audio_out_data <= 1'b0;
            underflow             <= 1'b0;
        end else if (!enable) begin
            state                 <= IDLE;
            shift_reg             <= '0;
            bit_cnt               <= '0;
            serial_audio_out_data <= 1'b0;
            underflow             <= 1'b0;
        end else if (frame_start) begin
            state                 <= LEFT;
            bit_cnt               <= '0;
            serial_audio_out_data <= 1'b0;
            if (pair_ready) begin
                shift_reg  <= fifo.left_read_data;
                right_hold <= fifo.right_read_data;
                underflow  <= 1'b0;
            end else begin
                shift_reg  <= '0;
                right_hold <= '0;
                underflow  <= 1'b1;
            end
        end else if (right_start) begin
            state                 <= RIGHT;
            shift_reg             <= right_hold;
            bit_cnt               <= '0;
            serial_audio_out_data <= 1'b0;
            underflow             <= 1'b0;
        end else begin
            underflow <= 1'b0;
            // Past the sample width the line pads with zeros and the counter parks.
            if (state != IDLE && bclk_falling_edge) begin
                if (bit_cnt < CNT_MAX) begin
                    serial_audio_out_data <= shift_reg[AUDIO_DATA_WIDTH-1];
                    shift_reg             <= {shift_reg[AUDIO_DATA_WIDTH-2:0], 1'b0};
                    bit_cnt               <= bit_cnt + 1'b1;
                end else begin
                    serial_audio_out_data <= 1'b0;
                end
            end
        end
    end

`ifdef AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            underflow_count <= 8'd0;
        else if (frame_start && !pair_ready && underflow_count != 8'hFF)
            underflow_count <= underflow_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_audio_fifo_serializer.sv
// Directed-vector bench: the driver queues expected bits/pops/underflows, a negedge monitor checks them.
module tb_audio_fifo_serializer;
    localparam int W = 16;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, bclk = 1'b0, lr_r = 1'b0, lr_f = 1'b0;
    logic serial, uf;
`ifdef AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN
    logic [7:0] uf_cnt;
`endif

    audio_fifo_serializer_if #(.AUDIO_DATA_WIDTH(W)) fif();

    audio_fifo_serializer #(.AUDIO_DATA_WIDTH(W), .BIT_COUNTER_WIDTH(6)) dut (
        .clk                   (clk),
        .reset                 (rst_n),
        .enable                (enable),
        .bclk_falling_edge     (bclk),
        .lrclk_rising_edge     (lr_r),
        .lrclk_falling_edge    (lr_f),
        .fifo                  (fif),
        .serial_audio_out_data (serial),
        .underflow             (uf)
`ifdef AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN
        ,
        .underflow_count       (uf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, pops = 0, exp_pops = 0, ufs = 0, exp_ufs = 0;
    logic exp_bits[$];
    logic exp_rd[$];
    logic exp_uf[$];
    logic bclk_d = 1'b0, fs_d = 1'b0, active = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: serial bit one clk after each BCLK strobe, pops on frame-start cycles, underflow one clk later.
    always @(negedge clk) begin
        logic e;
        if (rst_n) begin
            if (bclk_d) begin
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL bit_queue_underrun actual=empty expected=entry");
                end else begin
                    e = exp_bits.pop_front();
                    chk("serial_bit", serial, e);
                end
            end
            if (fs_d) begin
                if (exp_uf.size() == 0) begin
                    errors++;
                    $display("FAIL uf_queue_underrun actual=empty expected=entry");
                end else begin
                    e = exp_uf.pop_front();
                    chk("underflow", uf, e);
                end
            end else begin
                chk("no_spurious_underflow", uf, 0);
            end
            if (uf) ufs++;
            if (lr_f && enable) begin
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_queue_underrun actual=empty expected=entry");
                end else begin
                    e = exp_rd.pop_front();
                    chk("left_read_en", fif.left_read_en, e);
                    chk("right_read_en", fif.right_read_en, e);
                end
            end else begin
                chk("no_spurious_pop", fif.left_read_en | fif.right_read_en, 0);
            end
            if (fif.left_read_en) pops++;
        end
        bclk_d = rst_n && bclk;
        fs_d   = rst_n && lr_f && enable;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bit_of(input logic [W-1:0] w, input int i);
        return (active && i < W) ? w[W-1-i] : 1'b0;
    endfunction

    task automatic bclks(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            tick(); tick();
            bclk = 1'b1;
            exp_bits.push_back(bit_of(w, i));
            tick();
            bclk = 1'b0;
        end
        tick();
    endtask

    // One half-frame: LRCLK strobe (optionally with a coincident BCLK) then nb BCLKs.
    task automatic half(input bit left, input logic [W-1:0] w, input int nb, input bit co);
        logic ok;
        if (left) lr_f = 1'b1; else lr_r = 1'b1;
        if (left && enable) begin
            ok = !fif.left_fifo_is_empty && !fif.right_fifo_is_empty;
            exp_rd.push_back(ok);
            exp_uf.push_back(!ok);
            if (ok) exp_pops++; else exp_ufs++;
        end
        if (co) begin
            bclk = 1'b1;
            exp_bits.push_back(1'b0);
        end
        tick();
        lr_f = 1'b0; lr_r = 1'b0; bclk = 1'b0;
        bclks(w, nb);
    endtask

    task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input logic le, input logic re,
                         input int nb, input bit co);
        logic ok;
        ok = !le && !re;
        fif.left_read_data = l; fif.right_read_data = r;
        fif.left_fifo_is_empty = le; fif.right_fifo_is_empty = re;
        half(1'b1, ok ? l : '0, nb, 1'b0);
        // FIFO head moves on after a pop; the right half must come from the held word.
        fif.left_read_data = 16'hBEEF; fif.right_read_data = 16'hDEAD;
        half(1'b0, ok ? r : '0, nb, co);
    endtask

    initial begin
        fif.left_fifo_is_empty = 1'b0; fif.right_fifo_is_empty = 1'b0;
        fif.left_read_data = 16'hA5C3; fif.right_read_data = 16'h0F01;
        enable = 1'b1; lr_f = 1'b1;
        #12;
        chk("reset_serial", serial, 0);
        chk("reset_underflow", uf, 0);
        chk("reset_left_read_en", fif.left_read_en, 0);
        chk("reset_right_read_en", fif.right_read_en, 0);
        lr_f = 1'b0;
        tick(); rst_n = 1'b1; tick();
`ifdef AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN
        chk("count_after_reset", uf_cnt, 0);
`endif

        // Full 32-BCLK frame with a good pair.
        frame(16'hA5C3, 16'h0F01, 1'b0, 1'b0, 32, 1'b0);

        // Right FIFO empty: no pop, all-zero frame, one underflow.
        frame(16'h1234, 16'h5678, 1'b0, 1'b1, 32, 1'b0);
`ifdef AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN
        chk("count_after_one_uf", uf_cnt, 1);
`endif

        // Short half-frames; the right-start strobe coincides with a BCLK while 1s remain in shift.
        frame(16'hFFFF, 16'hC3C3, 1'b0, 1'b0, 8, 1'b1);

        // Disable mid-LEFT after 5 bits, re-enable before LRCLK rising.
        fif.left_read_data = 16'hFFFF; fif.right_read_data = 16'h0001;
        fif.left_fifo_is_empty = 1'b0; fif.right_fifo_is_empty = 1'b0;
        half(1'b1, 16'hFFFF, 5, 1'b0);
        chk("pre_disable_serial", serial, 1);
        enable = 1'b0;
        tick();
        chk("disable_serial_zero", serial, 0);
        enable = 1'b1;
        tick();
        active = 1'b0;
        half(1'b0, 16'h0001, 8, 1'b0);
        active = 1'b1;
        frame(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16, 1'b0);

        // Async reset mid-frame.
        fif.left_read_data = 16'h8000; fif.right_read_data = 16'h0001;
        half(1'b1, 16'h8000, 1, 1'b0);
        chk("pre_reset_serial", serial, 1);
        #2;
        rst_n = 1'b0;
        lr_f  = 1'b1;
        #1;
        chk("async_reset_serial", serial, 0);
        chk("async_reset_left_rd", fif.left_read_en, 0);
        chk("async_reset_right_rd", fif.right_read_en, 0);
        tick();
        lr_f = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN
        chk("count_cleared_by_reset", uf_cnt, 0);
`endif
        active = 1'b0;
        bclks(16'h0000, 4);
        active = 1'b1;
        frame(16'h8000, 16'h0001, 1'b0, 1'b0, 16, 1'b0);

        // Underflow storm.
        for (int n = 0; n < 300; n++)
            frame(16'h7777, 16'h9999, 1'b0, 1'b1, 1, 1'b0);
`ifdef AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN
        chk("count_saturated", uf_cnt, 255);
`endif

        repeat (5) tick();
        chk("bits_drained", exp_bits.size(), 0);
        chk("rd_drained", exp_rd.size(), 0);
        chk("uf_drained", exp_uf.size(), 0);
        chk("total_pops", pops, exp_pops);
        chk("total_underflows", ufs, exp_ufs);
        chk("storm_underflows", exp_ufs, 301);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_fifo_serializer.md
Name: audio_fifo_serializer

Overview:
- Read-side consumer of a pair of show-ahead sync FIFOs (left and right channel) in the audio DAC path.
- Pops one stereo sample pair per LRCLK frame and shifts it out MSB-first as I2S serial data to the codec DAC pin.
- Only pops when both FIFOs hold data, so channels stay paired.
- Flags underflow when the FIFOs run dry.

Parameters:
- AUDIO_DATA_WIDTH, 32, bits per channel sample; equals FIFO DATA_WIDTH.
- BIT_COUNTER_WIDTH, 6, width of the per-channel bit counter; must satisfy 2^BIT_COUNTER_WIDTH > AUDIO_DATA_WIDTH.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  playback enable
- bclk_falling_edge  input  1  one-clk strobe, codec BCLK falling edge
- lrclk_rising_edge  input  1  one-clk strobe, start of right half-frame
- lrclk_falling_edge  input  1  one-clk strobe, start of left half-frame
- left_fifo_is_empty  input  1  left FIFO empty
- left_read_data  input  AUDIO_DATA_WIDTH  left FIFO head word (show-ahead)
- right_fifo_is_empty  input  1  right FIFO empty
- right_read_data  input  AUDIO_DATA_WIDTH  right FIFO head word (show-ahead)
- left_read_en  output  1  left FIFO pop
- right_read_en  output  1  right FIFO pop
- serial_audio_out_data  output  1  I2S DAC data
- underflow  output  1  one-clk pulse, frame started with a FIFO empty

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; shift register, right holding register and bit counter cleared.
  - serial_audio_out_data=0, underflow=0, read enables=0.
- States: IDLE, LEFT, RIGHT.
  - IDLE -> LEFT on lrclk_falling_edge & enable.
  - LEFT -> RIGHT on lrclk_rising_edge.
  - RIGHT -> LEFT on lrclk_falling_edge & enable.
  - Any state -> IDLE when enable=0; takes effect the same cycle and overrides all other events.
  - enable rising mid-frame waits in IDLE for the next lrclk_falling_edge; a frame never starts on the right channel.
- Frame start (lrclk_falling_edge & enable):
  - Both empties low: left_read_en and right_read_en asserted combinationally for exactly that cycle. shift <= left_read_data, right_hold <= right_read_data.
  - Otherwise: no pop on either FIFO (never pop one alone); shift and right_hold <= 0; underflow pulses for 1 clk.
- Right start (lrclk_rising_edge in LEFT): shift <= right_hold. No FIFO access.
- Bit counter cleared on every LRCLK edge load.
- Serialization (LEFT/RIGHT, I2S one-BCLK delay):
  - In the cycle of an LRCLK edge, serial_audio_out_data <= 0, even if bclk_falling_edge coincides.
  - On each later bclk_falling_edge with bit counter < AUDIO_DATA_WIDTH: output <= shift[MSB], shift <<= 1, counter++.
  - Counter == AUDIO_DATA_WIDTH: output 0 (pad) and the counter holds.
  - Fewer BCLKs than AUDIO_DATA_WIDTH in a half-frame: the remaining LSBs are dropped at the next LRCLK edge.
- Output is registered and changes only on bclk_falling_edge, LRCLK edge or enable=0 cycles; holds otherwise.
- IDLE: output 0, no reads.
- Latency: the sample MSB appears on the 1st bclk_falling_edge after the LRCLK edge.

Optional Feature:
- Macro: AUDIO_FIFO_SERIALIZER_UNDERFLOW_COUNT_EN.
- Defined:
  - Adds output port underflow_count [7:0].
  - Increments on each underflow pulse and saturates at 255.
  - Cleared only by reset.
- Undefined: port absent; underflow pulse still present.

Test Plan:
- AUDIO_DATA_WIDTH=16, 32 BCLKs per half-frame. Left FIFO head 16'hA5C3, right head 16'h0F01, both non-empty, enable=1, lrclk_falling_edge -> both read_en high exactly 1 clk. Line after the delay bit: 1010010111000011 then 16 zeros; after lrclk_rising_edge: 0000111100000001 then zeros; underflow stays 0.
- Left non-empty, right_fifo_is_empty=1 at frame start -> no read_en on either FIFO; 64 zero bits output; underflow 1 clk; counter (macro on) 0->1.
- Only 8 BCLKs per half-frame with left 16'hFFFF -> 8 ones output, then reload at lrclk_rising_edge; no extra pops.
- enable dropped mid-LEFT after 5 bits -> output 0 next clk, state IDLE. enable re-raised before lrclk_rising_edge -> nothing until the next lrclk_falling_edge, which pops one pair.
- reset asserted mid-frame with data 16'h8000 -> output 0 and read_en 0 immediately, without waiting for clk; after release no pop until lrclk_falling_edge.
- 300 consecutive underflow frames (macro on) -> underflow_count saturates at 255; 300 underflow pulses seen.
